// File: rtl/tdm_demux8_if.sv
// Bus bundle for the TDM receive path: tagged word stream in, published frame and status out.
interface tdm_demux8_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   din;
  logic [2:0]         ch;
  logic               din_valid;
  logic               frame_start;
  logic [8*WIDTH-1:0] dout;
  logic [7:0]         ch_mask;
  logic               busy;
  logic               frame_done;
  logic               dup_err;
  logic               timeout_err;

  modport master (
    output din, ch, din_valid, frame_start,
    input  dout, ch_mask, busy, frame_done, dup_err, timeout_err
  );

  modport slave (
    input  din, ch, din_valid, frame_start,
    output dout, ch_mask, busy, frame_done, dup_err, timeout_err
  );
endinterface

// File: rtl/tdm_demux8.sv
// 8-channel TDM de-multiplexer: collects one tagged word per channel into a shadow
// frame and publishes it on dout when all channels have arrived.
//
// state   | meaning
// IDLE    | waiting for a frame_start word
// COLLECT | gathering channel words; mask all-ones means completion cycle
module tdm_demux8 #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst_n,
  tdm_demux8_if.slave bus
);
  typedef enum logic {IDLE, COLLECT} state_e;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e                    state_q;
  logic [7:0][WIDTH-1:0]     shadow_q;
  logic [7:0][WIDTH-1:0]     dout_q;
  logic [7:0]                mask_q;
  logic [7:0]                timer_q;
  logic                      frame_done_q;
  logic                      dup_err_q;
  logic                      timeout_err_q;

  logic start_w;
  assign start_w = bus.din_valid && bus.frame_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      dout_q        <= '0;
      mask_q        <= '0;
      timer_q       <= '0;
      frame_done_q  <= 1'b0;
      dup_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      dup_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_w) begin
            shadow_q[bus.ch] <= bus.din;
            mask_q           <= 8'b1 << bus.ch;
            timer_q          <= '0;
            state_q          <= COLLECT;
          end
        end
        COLLECT: begin
          if (mask_q == 8'hFF) begin
            // Completion cycle: publish, then treat the incoming word as if idle.
            dout_q       <= shadow_q;
            frame_done_q <= 1'b1;
            mask_q       <= '0;
            state_q      <= IDLE;
            if (start_w) begin
              shadow_q[bus.ch] <= bus.din;
              mask_q           <= 8'b1 << bus.ch;
              timer_q          <= '0;
              state_q          <= COLLECT;
            end
          end else if (start_w) begin
            timeout_err_q    <= 1'b1;
            shadow_q[bus.ch] <= bus.din;
            mask_q           <= 8'b1 << bus.ch;
            timer_q          <= '0;
          end else if (bus.din_valid) begin
            timer_q <= '0;
            if (mask_q[bus.ch]) begin
              dup_err_q <= 1'b1;
            end else begin
              shadow_q[bus.ch] <= bus.din;
              mask_q[bus.ch]   <= 1'b1;
            end
          end else if (timer_q == TIMER_LAST) begin
            timeout_err_q <= 1'b1;
            mask_q        <= '0;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.dout        = dout_q;
  assign bus.ch_mask     = mask_q;
  assign bus.busy        = (state_q == COLLECT);
  assign bus.frame_done  = frame_done_q;
  assign bus.dup_err     = dup_err_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8: stimulus pushes expected frames, a monitor pops on frame_done.
module tb_tdm_demux8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux8_if #(.WIDTH(4)) bus ();
  tdm_demux8 #(.WIDTH(4), .TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nvec = 0;
  int nmis = 0;
  int dup_seen = 0;
  int to_seen = 0;
  int fd_seen = 0;
  int n_pushed = 0;

  logic [31:0] exp_q[$];
  logic [7:0][3:0] msh = '0;
  logic [7:0] mmask = '0;
  logic [31:0] last_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model updated as each word is issued; completed frames go to the queue.
  task automatic word(input int c, input logic [3:0] d, input bit fs);
    bus.ch = 3'(c);
    bus.din = d;
    bus.din_valid = 1'b1;
    bus.frame_start = fs;
    if (fs) begin
      mmask = 8'b1 << c;
      msh[c] = d;
    end else if (mmask != 0 && !mmask[c]) begin
      msh[c] = d;
      mmask[c] = 1'b1;
    end
    if (mmask == 8'hFF) begin
      exp_q.push_back(msh);
      last_dout = msh;
      n_pushed++;
      mmask = '0;
    end
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.dup_err) dup_seen++;
      if (bus.timeout_err) to_seen++;
      if (bus.frame_done) begin
        fd_seen++;
        if (exp_q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL frame_unexpected: got dout %h expected no frame", bus.dout);
        end else begin
          chk("frame_dout", bus.dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[8];
    int j, t;
    bus.din = '0; bus.ch = '0; bus.din_valid = 1'b0; bus.frame_start = 1'b0;

    // T1 reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_mask", 32'(bus.ch_mask), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_pulses", {29'h0, bus.frame_done, bus.dup_err, bus.timeout_err}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // T2 ordered frame
    for (int k = 0; k < 8; k++) word(k, 4'(k + 1), k == 0);
    chk("t2_mask_full", 32'(bus.ch_mask), 32'hFF);
    chk("t2_busy_cpl", 32'(bus.busy), 32'h1);
    chk("t2_fd_early", 32'(bus.frame_done), 32'h0);
    idle(1);
    chk("t2_fd", 32'(bus.frame_done), 32'h1);
    chk("t2_dout", bus.dout, 32'h87654321);
    chk("t2_mask_clr", 32'(bus.ch_mask), 32'h0);
    chk("t2_busy_idle", 32'(bus.busy), 32'h0);
    idle(1);
    chk("t2_fd_width", 32'(bus.frame_done), 32'h0);

    // T4 duplicate
    word(0, 4'h1, 1);
    word(2, 4'hA, 0);
    word(2, 4'h5, 0);
    chk("t4_dup", 32'(bus.dup_err), 32'h1);
    word(1, 4'h2, 0);
    chk("t4_dup_width", 32'(bus.dup_err), 32'h0);
    for (int k = 3; k < 8; k++) word(k, 4'(k + 1), 0);
    idle(1);
    chk("t4_dout", bus.dout, 32'h87654A21);
    idle(1);

    // T5 timeout after TIMEOUT idle cycles
    word(0, 4'h3, 1); word(1, 4'h4, 0); word(2, 4'h5, 0);
    idle(15);
    chk("t5_to", 32'(bus.timeout_err), 32'h1);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_mask", 32'(bus.ch_mask), 32'h0);
    chk("t5_dout_kept", bus.dout, 32'h87654A21);
    mmask = '0;
    // TIMEOUT-1 idle cycles must not abort
    word(0, 4'hE, 1); word(1, 4'hD, 0); word(2, 4'hC, 0);
    idle(14);
    chk("t5_no_to", 32'(bus.timeout_err), 32'h0);
    chk("t5_still_busy", 32'(bus.busy), 32'h1);
    chk("t5_mask_kept", 32'(bus.ch_mask), 32'h07);
    for (int k = 3; k < 8; k++) word(k, 4'(k), 0);
    idle(1);
    chk("t5_dout", bus.dout, 32'h76543CDE);
    idle(1);

    // T6 restart then reset mid-frame
    word(0, 4'h9, 1); word(1, 4'h9, 0); word(4, 4'h9, 0);
    word(5, 4'hC, 1);
    chk("t6_restart_to", 32'(bus.timeout_err), 32'h1);
    chk("t6_restart_mask", 32'(bus.ch_mask), 32'h20);
    word(6, 4'h1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_dout", bus.dout, 32'h0);
    chk("t6_rst_mask", 32'(bus.ch_mask), 32'h0);
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    chk("t6_rst_pulses", {29'h0, bus.frame_done, bus.dup_err, bus.timeout_err}, 32'h0);
    rst_n = 1'b1;
    mmask = '0;
    last_dout = '0;
    idle(1);
    chk("t6_post_rst_to", 32'(to_seen), 32'd2);

    // T3 random channel order with 0..3 idle gaps
    for (int f = 0; f < 500; f++) begin
      for (int i = 0; i < 8; i++) ord[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int k = 0; k < 8; k++) begin
        word(ord[k], 4'($urandom % 16), k == 0);
        idle(int'($urandom_range(3, 0)));
      end
    end
    idle(3);
    chk("t3_last_dout", bus.dout, last_dout);

    chk("frames_left", 32'(exp_q.size()), 32'd0);
    chk("frame_count", 32'(fd_seen), 32'(n_pushed));
    chk("dup_count", 32'(dup_seen), 32'd1);
    chk("timeout_count", 32'(to_seen), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
